mbscore_mem_arbiter: RTL and testbench

- Arbitrates a single unified memory port between two requesters of the MBScore core: instruction fetch (IF, read-only) and data memory access (DM, read/write).
- Sits between the pipeline stages and the external memory.
- Grants one transaction at a time and registers all memory-side signals.
- Routes the completion and read data back to the owning requester.
- DM has priority; a starvation counter guarantees IF forward progress.

---
 rtl/mbscore_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mbscore_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbscore_mem_arbiter.sv
// Two-requester (instruction fetch / data memory) arbiter for the single MBScore memory port.
// Optional performance counters are enabled by defining MBSCORE_ARB_PERF_CNT_EN.
module mbscore_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [3:0]            dm_be,
    output logic                  dm_gnt,
    output logic                  dm_done,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
`ifdef MBSCORE_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_wait_cnt,
    output logic [15:0]           perf_force_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_if_sel;
    logic                  w_dm_sel;
    logic                  w_starved;
    logic [3:0]            r_starve_cnt;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic                  r_busy;
    logic                  r_if_done;
    logic                  r_dm_done;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DM wins unless IF has been passed over STARVE_MAX times in a row
    always_comb begin
        w_state_next = r_state;
        w_if_sel     = 1'b0;
        w_dm_sel     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dm_req && !(if_req && w_starved)) begin
                    w_dm_sel     = 1'b1;
                    w_state_next = ST_DM_BUSY;
                end else if (if_req) begin
                    w_if_sel     = 1'b1;
                    w_state_next = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                if (mem_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign if_gnt = w_if_sel & ~rst;
    assign dm_gnt = w_dm_sel & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'h0;
            r_busy      <= 1'b0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dm_sel) begin
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_mem_be    <= dm_be;
                    end else if (w_if_sel) begin
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= 4'hF;
                    end
                end
                ST_IF_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_if_done  <= 1'b1;
                        r_if_rdata <= mem_rdata;
                    end
                end
                ST_DM_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_dm_done <= 1'b1;
                        if (!r_mem_we) begin
                            r_dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Counts consecutive DM wins while IF is waiting; only meaningful in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_if_sel || !if_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_dm_sel && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

`ifdef MBSCORE_ARB_PERF_CNT_EN
    logic [31:0] r_perf_wait_cnt;
    logic [15:0] r_perf_force_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_wait_cnt  <= 32'd0;
            r_perf_force_cnt <= 16'd0;
        end else begin
            if ((if_req || dm_req) && !(w_if_sel || w_dm_sel)) begin
                r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
            end
            if (w_if_sel && dm_req && w_starved) begin
                r_perf_force_cnt <= r_perf_force_cnt + 16'd1;
            end
        end
    end

    assign perf_wait_cnt  = r_perf_wait_cnt;
    assign perf_force_cnt = r_perf_force_cnt;
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign busy      = r_busy;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mbscore_mem_arbiter.sv
// Bench for mbscore_mem_arbiter: directed scenarios, then random requester/memory traffic
// checked every cycle against a transaction-level model.
module tb_mbscore_mem_arbiter;

    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [DW-1:0] if_addr = '0;
    logic          if_gnt, if_done;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [DW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_be = 4'h0;
    logic          dm_gnt, dm_done;
    logic [DW-1:0] dm_rdata;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
`ifdef MBSCORE_ARB_PERF_CNT_EN
    logic [31:0]   perf_wait_cnt;
    logic [15:0]   perf_force_cnt;
`endif

    mbscore_mem_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MBSCORE_ARB_PERF_CNT_EN
        , .perf_wait_cnt(perf_wait_cnt), .perf_force_cnt(perf_force_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Transaction-level model: one outstanding transaction, its owner and payload
    bit            m_busy, m_owner_dm, m_we;
    logic [DW-1:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic [3:0]    m_be;
    bit            m_if_done, m_dm_done;
    int            m_passed_over;   // DM wins in a row while IF was waiting
    bit            e_if_gnt, e_dm_gnt;
    logic [31:0]   m_wait_cnt;
    logic [15:0]   m_force_cnt;
    int            mem_delay;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_dm = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        m_if_done = 0; m_dm_done = 0;
        m_if_rdata = '0; m_dm_rdata = '0;
        m_passed_over = 0;
        m_wait_cnt = '0; m_force_cnt = '0;
    endtask

    task automatic check_all();
        if (rst || m_busy) begin
            e_dm_gnt = 0;
            e_if_gnt = 0;
        end else begin
            e_dm_gnt = dm_req && !(if_req && m_passed_over == SM);
            e_if_gnt = !e_dm_gnt && if_req;
        end
        cmp("if_gnt", {31'd0, if_gnt}, {31'd0, e_if_gnt});
        cmp("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dm_gnt});
        if (rst) begin
            cmp("rst_mem_req", {31'd0, mem_req}, 32'd0);
            cmp("rst_busy", {31'd0, busy}, 32'd0);
            cmp("rst_done", {30'd0, if_done, dm_done}, 32'd0);
            cmp("rst_if_rdata", if_rdata, 32'd0);
            cmp("rst_dm_rdata", dm_rdata, 32'd0);
        end else begin
            cmp("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
            cmp("busy", {31'd0, busy}, {31'd0, m_busy});
            cmp("if_done", {31'd0, if_done}, {31'd0, m_if_done});
            cmp("dm_done", {31'd0, dm_done}, {31'd0, m_dm_done});
            cmp("if_rdata", if_rdata, m_if_rdata);
            cmp("dm_rdata", dm_rdata, m_dm_rdata);
            if (m_busy) begin
                cmp("mem_we", {31'd0, mem_we}, {31'd0, m_we});
                cmp("mem_addr", mem_addr, m_addr);
                cmp("mem_be", {28'd0, mem_be}, {28'd0, m_be});
                if (m_owner_dm && m_we) cmp("mem_wdata", mem_wdata, m_wdata);
            end
`ifdef MBSCORE_ARB_PERF_CNT_EN
            cmp("perf_wait", perf_wait_cnt, m_wait_cnt);
            cmp("perf_force", {16'd0, perf_force_cnt}, {16'd0, m_force_cnt});
`endif
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if ((if_req || dm_req) && !(e_if_gnt || e_dm_gnt)) m_wait_cnt = m_wait_cnt + 1;
        if (e_if_gnt && dm_req && m_passed_over == SM) m_force_cnt = m_force_cnt + 1;
        m_if_done = 0;
        m_dm_done = 0;
        if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
                if (m_owner_dm) begin
                    m_dm_done = 1;
                    if (!m_we) m_dm_rdata = mem_rdata;
                    $display("txn DM %s addr=%h data=%h", m_we ? "wr" : "rd", m_addr,
                             m_we ? m_wdata : mem_rdata);
                end else begin
                    m_if_done = 1;
                    m_if_rdata = mem_rdata;
                    $display("txn IF rd addr=%h data=%h", m_addr, mem_rdata);
                end
            end
        end else begin
            if (e_if_gnt || !if_req) m_passed_over = 0;
            else if (e_dm_gnt && m_passed_over < SM) m_passed_over++;
            if (e_dm_gnt) begin
                m_busy = 1; m_owner_dm = 1; m_we = dm_we;
                m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
            end else if (e_if_gnt) begin
                m_busy = 1; m_owner_dm = 0; m_we = 0;
                m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
            end
            if (e_dm_gnt || e_if_gnt) mem_delay = int'($urandom_range(0, 3));
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic drive_rand();
        rst = ($urandom_range(0, 399) == 0);
        if (!if_req || e_if_gnt) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
        end
        if (!dm_req || e_dm_gnt) begin
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = $urandom_range(0, 1);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_be    = 4'($urandom_range(0, 15));
        end
        mem_rdata = $urandom;
        if (m_busy) begin
            if (mem_delay == 0) begin
                mem_ack = 1;
            end else begin
                mem_ack = 0;
                mem_delay--;
            end
        end else begin
            mem_ack = ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        int k;
        model_reset();
        mem_delay = 0;
        repeat (3) @(posedge clk);
        #1;
        half();
        cmp("reset_mem_req", {31'd0, mem_req}, 32'd0);
        cmp("reset_busy", {31'd0, busy}, 32'd0);
        fin();
        rst = 0;
        tick();

        // DM read, ack three cycles after mem_req rises
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        half(); cmp("rd_gnt", {31'd0, dm_gnt}, 32'd1); fin();
        dm_req = 0;
        half();
        cmp("rd_mem_addr", mem_addr, 32'h100);
        cmp("rd_mem_we", {31'd0, mem_we}, 32'd0);
        fin();
        tick();
        tick();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 0; mem_rdata = '0;
        half();
        cmp("rd_done", {31'd0, dm_done}, 32'd1);
        cmp("rd_data", dm_rdata, 32'hDEADBEEF);
        cmp("rd_no_if_done", {31'd0, if_done}, 32'd0);
        fin();
        half(); cmp("rd_done_pulse", {31'd0, dm_done}, 32'd0); fin();

        // DM write, immediate ack
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678; dm_be = 4'b0011;
        half(); cmp("wr_gnt", {31'd0, dm_gnt}, 32'd1); fin();
        dm_req = 0; mem_ack = 1; mem_rdata = 32'h55555555;
        half();
        cmp("wr_mem_we", {31'd0, mem_we}, 32'd1);
        cmp("wr_mem_be", {28'd0, mem_be}, 32'h3);
        cmp("wr_mem_wdata", mem_wdata, 32'h12345678);
        fin();
        mem_ack = 0;
        half();
        cmp("wr_done", {31'd0, dm_done}, 32'd1);
        cmp("wr_rdata_held", dm_rdata, 32'hDEADBEEF);
        fin();

        // Reset while an IF fetch is outstanding
        if_req = 1; if_addr = 32'h0;
        half(); cmp("rst_if_gnt", {31'd0, if_gnt}, 32'd1); fin();
        if_req = 0;
        tick();
        rst = 1;
        #1;
        cmp("rst_mem_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        rst = 0;
        half();
        cmp("rst_no_if_done", {31'd0, if_done}, 32'd0);
        cmp("rst_idle", {31'd0, busy}, 32'd0);
        fin();
        if_req = 1; if_addr = 32'h8;
        half(); cmp("rerq_gnt", {31'd0, if_gnt}, 32'd1); fin();
        if_req = 0; mem_ack = 1; mem_rdata = 32'hCAFE0008;
        tick();
        mem_ack = 0;
        half();
        cmp("rerq_done", {31'd0, if_done}, 32'd1);
        cmp("rerq_data", if_rdata, 32'hCAFE0008);
        fin();

        // Both requesters held, ack every cycle: DM x4 then IF, repeating
        if_req = 1; if_addr = 32'h1000; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
            half();
            if (if_gnt || dm_gnt) begin
                cmp("starve_if_gnt", {31'd0, if_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
                cmp("starve_dm_gnt", {31'd0, dm_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
                k++;
            end
            fin();
            if (k == 10) begin
                if_req = 0;
                dm_req = 0;
            end
        end
        cmp("starve_grant_count", k, 10);
        if_req = 0; dm_req = 0;
        tick();
        mem_ack = 0;
        tick();
`ifdef MBSCORE_ARB_PERF_CNT_EN
        cmp("starve_force_cnt", {16'd0, perf_force_cnt}, 32'd2);
`endif

        // Spurious ack while idle, then IF fetch at 0x40
        mem_ack = 1;
        tick();
        tick();
        mem_ack = 0; if_req = 1; if_addr = 32'h40;
        half(); cmp("sp_if_gnt", {31'd0, if_gnt}, 32'd1); fin();
        if_req = 0;
        half();
        cmp("sp_mem_addr", mem_addr, 32'h40);
        cmp("sp_mem_be", {28'd0, mem_be}, 32'hF);
        fin();
        mem_ack = 1; mem_rdata = 32'h44444444;
        tick();
        mem_ack = 0;
        tick();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            drive_rand();
            tick();
        end
        rst = 0; if_req = 0; dm_req = 0; mem_ack = 1;
        repeat (4) tick();
        mem_ack = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
